// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// operand-forward select codes and the memory-wait timeout default.
package hazard_pkg;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/hazard_forwarding_unit.sv
// Operand bypass selection for both execute-stage sources; the youngest
// writer (M) wins over W, and x0 or an unused source never forwards.
module forwarding_unit
    import hazard_pkg::*;
(
    input  logic [4:0] RS1_E,
    input  logic [4:0] RS2_E,
    input  logic [1:0] RS_valid_E,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E
);

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       rs_used,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (rs_used && we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (rs_used && we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_W;
        end else begin
            return FWD_RF;
        end
    endfunction

    // Per-operand select, same rule for both sources
    always_comb begin
        ForwardA_E = fwd_sel(RS1_E, RS_valid_E[0], RdM, RegWriteM, RdW, RegWriteW);
        ForwardB_E = fwd_sel(RS2_E, RS_valid_E[1], RdM, RegWriteM, RdW, RegWriteW);
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// data-memory freeze with a watchdog timeout, and stall/flush counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RS1_D,
    input  logic [4:0]  RS2_D,
    input  logic [1:0]  RS_valid_D,
    input  logic [4:0]  RS1_E,
    input  logic [4:0]  RS2_E,
    input  logic [1:0]  RS_valid_E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        MemReadE,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        branch_taken_E,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_D,
    output logic        flush_E,
    output logic [1:0]  ForwardA_E,
    output logic [1:0]  ForwardB_E,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic       frz_s;
    logic       lu_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;
    logic       unused_s;

    logic [0:0]  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic [15:0] stall_cnt_q, flush_cnt_q;

    // The write flag of the E stage is not needed: only loads create a use hazard.
    assign unused_s = RegWriteE;

    forwarding_unit u_fwd (
        .RS1_E      (RS1_E),
        .RS2_E      (RS2_E),
        .RS_valid_E (RS_valid_E),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ForwardA_E (fwd_a_s),
        .ForwardB_E (fwd_b_s)
    );

    // Hazard detection and prioritised stall/flush/forward outputs
    always_comb begin
        frz_s = dmem_req & ~dmem_ready;
        lu_s  = MemReadE & (RdE != 5'd0) &
                (((RdE == RS1_D) & RS_valid_D[0]) | ((RdE == RS2_D) & RS_valid_D[1]));
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        stall_E    = 1'b0;
        stall_M    = 1'b0;
        flush_D    = 1'b0;
        flush_E    = 1'b0;
        ForwardA_E = FWD_RF;
        ForwardB_E = FWD_RF;
        if (rst) begin
            ForwardA_E = FWD_RF;
        end else begin
            ForwardA_E = fwd_a_s;
            ForwardB_E = fwd_b_s;
            // A branch seen during a freeze stays parked in the frozen E stage.
            if (frz_s) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
            end else if (branch_taken_E) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (lu_s) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end else begin
                stall_F = 1'b0;
            end
        end
    end

    // Memory-wait FSM next state with watchdog
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                if (frz_s) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (wait_cnt_q != TIMEOUT_C) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
                if (wait_cnt_d == TIMEOUT_C) begin
                    mem_timeout_d = 1'b1;
                end else begin
                    mem_timeout_d = mem_timeout_q;
                end
                // Once timed out the FSM parks here until reset.
                if (frz_s || mem_timeout_d) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // State, watchdog and performance counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= 16'd0;
            flush_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_D ? sat_inc16(stall_cnt_q) : stall_cnt_q;
            flush_cnt_q   <= flush_E ? sat_inc16(flush_cnt_q) : flush_cnt_q;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with an in-bench reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_hazard_controller;

    localparam int TP = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  RS1_D, RS2_D, RS1_E, RS2_E, RdE, RdM, RdW;
    logic [1:0]  RS_valid_D, RS_valid_E;
    logic        MemReadE, RegWriteE, RegWriteM, RegWriteW;
    logic        branch_taken_E, dmem_req, dmem_ready;
    logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_wait   = 1'b0;
    int m_waited = 0;
    bit m_tmo    = 1'b0;
    int m_stalls = 0;
    int m_flush  = 0;

    hazard_controller #(.TIMEOUT(TP)) dut (
        .clk(clk), .rst(rst),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS_valid_D(RS_valid_D),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .RS_valid_E(RS_valid_E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .MemReadE(MemReadE), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .branch_taken_E(branch_taken_E), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which action wins this cycle: 3 freeze, 2 branch, 1 load-use, 0 none.
    function automatic int action();
        bit frz, lu;
        frz = dmem_req && !dmem_ready;
        lu  = MemReadE && RdE != 0 &&
              ((RdE == RS1_D && RS_valid_D[0]) || (RdE == RS2_D && RS_valid_D[1]));
        if (rst) return 0;
        if (frz) return 3;
        if (branch_taken_E) return 2;
        if (lu) return 1;
        return 0;
    endfunction

    // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E} for each action
    function automatic logic [5:0] exp_ctrl();
        logic [5:0] table_v [4];
        table_v[0] = 6'b000000;
        table_v[1] = 6'b110001;
        table_v[2] = 6'b000011;
        table_v[3] = 6'b111100;
        return table_v[action()];
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input logic used);
        if (rst || !used) return 2'b00;
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [15:0] sat(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    // Model of the registered behaviour, stepped on each rising edge
    always @(posedge clk) begin
        logic [5:0] c;
        bit frz;
        c   = exp_ctrl();
        frz = dmem_req && !dmem_ready;
        if (rst) begin
            m_wait <= 1'b0; m_waited <= 0; m_tmo <= 1'b0; m_stalls <= 0; m_flush <= 0;
        end else begin
            m_stalls <= m_stalls + int'(c[4]);
            m_flush  <= m_flush + int'(c[0]);
            if (!m_wait) begin
                if (frz) begin
                    m_wait <= 1'b1; m_waited <= 0;
                end
            end else begin
                m_waited <= m_waited + 1;
                if (m_waited + 1 >= TP) m_tmo <= 1'b1;
                m_wait <= frz || m_tmo || (m_waited + 1 >= TP);
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        logic [5:0] c;
        c = exp_ctrl();
        chk("stall_F", 32'(stall_F), 32'(c[5]));
        chk("stall_D", 32'(stall_D), 32'(c[4]));
        chk("stall_E", 32'(stall_E), 32'(c[3]));
        chk("stall_M", 32'(stall_M), 32'(c[2]));
        chk("flush_D", 32'(flush_D), 32'(c[1]));
        chk("flush_E", 32'(flush_E), 32'(c[0]));
        chk("ForwardA_E", 32'(ForwardA_E), 32'(exp_fwd(RS1_E, RS_valid_E[0])));
        chk("ForwardB_E", 32'(ForwardB_E), 32'(exp_fwd(RS2_E, RS_valid_E[1])));
        chk("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
        chk("stall_cnt", 32'(stall_cnt), 32'(sat(m_stalls)));
        chk("flush_cnt", 32'(flush_cnt), 32'(sat(m_flush)));
        chk("state", 32'(dut.state_q), 32'(m_wait));
    end

    task automatic idle();
        RS1_D = 5'd0; RS2_D = 5'd0; RS_valid_D = 2'b00;
        RS1_E = 5'd0; RS2_E = 5'd0; RS_valid_E = 2'b00;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        MemReadE = 1'b0; RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        branch_taken_E = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        MemReadE = 1'b1; RdE = 5'd5; RS1_D = 5'd5; RS_valid_D = 2'b01;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // forwarding and freeze conditions present, but reset masks them
        RegWriteM = 1'b1; RdM = 5'd3; RS1_E = 5'd3; RS_valid_E = 2'b11;
        dmem_req = 1'b1;
        #3;
        chk("rst ForwardA", 32'(ForwardA_E), 32'h0);
        chk("rst stall_F", 32'(stall_F), 32'h0);
        tick(); tick();
        #3;
        chk("rst stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst timeout", 32'(mem_timeout), 32'h0);

        // load-use
        tick(); rst = 1'b0; idle(); set_lu(); #3;
        chk("lu stall_F", 32'(stall_F), 32'h1);
        chk("lu stall_D", 32'(stall_D), 32'h1);
        chk("lu flush_E", 32'(flush_E), 32'h1);
        tick(); idle(); #3;
        chk("lu stall_cnt", 32'(stall_cnt), 32'h1);
        chk("lu flush_cnt", 32'(flush_cnt), 32'h1);
        chk("lu released", 32'(stall_D), 32'h0);

        // forwarding priority
        tick();
        RdM = 5'd3; RdW = 5'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
        RS1_E = 5'd3; RS_valid_E = 2'b01; #3;
        chk("fwd M wins", 32'(ForwardA_E), 32'h2);
        tick(); RdM = 5'd0; #3;
        chk("fwd W", 32'(ForwardA_E), 32'h1);
        tick(); RS_valid_E = 2'b00; #3;
        chk("fwd unused", 32'(ForwardA_E), 32'h0);
        tick(); RdM = 5'd3; RS2_E = 5'd3; RS_valid_E = 2'b10; #3;
        chk("fwd B M", 32'(ForwardB_E), 32'h2);
        chk("fwd A off", 32'(ForwardA_E), 32'h0);

        // branch beats load-use
        tick(); idle(); set_lu(); branch_taken_E = 1'b1; #3;
        chk("br flush_D", 32'(flush_D), 32'h1);
        chk("br flush_E", 32'(flush_E), 32'h1);
        chk("br stall_D", 32'(stall_D), 32'h0);

        // memory wait with a branch parked in E
        tick(); idle(); rst = 1'b1;
        tick(); rst = 1'b0; dmem_req = 1'b1; branch_taken_E = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("frz stalls", 32'({stall_F, stall_D, stall_E, stall_M}), 32'hF);
            chk("frz flush_D", 32'(flush_D), 32'h0);
            tick();
            chk("frz state", 32'(dut.state_q), 32'h1);
        end
        dmem_ready = 1'b1; #3;
        chk("frz done", 32'(stall_F), 32'h0);
        chk("late flush", 32'(flush_D), 32'h1);
        tick(); idle(); #3;
        chk("back RUN", 32'(dut.state_q), 32'h0);
        chk("frz stall_cnt", 32'(stall_cnt), 32'h3);
        chk("frz flush_cnt", 32'(flush_cnt), 32'h1);

        // watchdog
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #3;
        chk("tmo early", 32'(mem_timeout), 32'h0);
        tick(); #3;
        chk("tmo set", 32'(mem_timeout), 32'h1);
        tick(); dmem_ready = 1'b1; #3;
        chk("tmo sticky", 32'(mem_timeout), 32'h1);
        tick(); idle(); #3;
        chk("tmo sticky idle", 32'(mem_timeout), 32'h1);
        tick(); rst = 1'b1; tick(); #3;
        chk("tmo cleared", 32'(mem_timeout), 32'h0);

        // saturation, then reset during a memory wait
        rst = 1'b0; set_lu();
        for (int i = 0; i < 65535; i++) tick();
        #3;
        chk("stall_cnt max", 32'(stall_cnt), 32'hFFFF);
        tick(); #3;
        chk("stall_cnt sat", 32'(stall_cnt), 32'hFFFF);
        chk("flush_cnt sat", 32'(flush_cnt), 32'hFFFF);
        tick(); idle(); dmem_req = 1'b1;
        tick(); #3;
        chk("wait before rst", 32'(dut.state_q), 32'h1);
        rst = 1'b1; #1;
        chk("rst mask stall", 32'(stall_M), 32'h0);
        tick(); #3;
        chk("rst state", 32'(dut.state_q), 32'h0);
        chk("rst stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst flush_cnt", 32'(flush_cnt), 32'h0);
        tick(); idle(); rst = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
